// File: rtl/neuron_pe.sv
// Single-neuron processing element: bias plus NUM_IN signed products, then
// rescale, saturate and ReLU into one Q2.(N-2) activation on valid/ready.
module neuron_pe #(
   parameter int N      = 16,
   parameter int NUM_IN = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         clear,
   input  logic [N-1:0] bias,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] inp,
   input  logic [N-1:0] weight,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out,
   output logic         busy
);

   localparam int FRAC  = N - 2;
   localparam int ACC_W = 2 * N + 8;
   localparam int CNT_W = $clog2(NUM_IN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_IN - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACC   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_SAT   = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [2*N-1:0]     prod_q, prod_d;
   logic               pv_q, pv_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N-1:0]       out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               in_ready_q, in_ready_d;
   logic               busy_q, busy_d;

   logic [2*N-1:0]     mul_s;
   logic [ACC_W-1:0]   prod_ext_s;
   logic [ACC_W-1:0]   bias_ext_s;
   logic               beat_s;

   // Drop the FRAC fraction bits, clamp negatives to zero and large values to max.
   function automatic logic [N-1:0] sat_relu(input logic [ACC_W-1:0] a);
      logic [ACC_W-FRAC-1:0] s;
      s = a[ACC_W-1:FRAC];
      if (s[ACC_W-FRAC-1]) begin
         sat_relu = {N{1'b0}};
      end else if (|s[ACC_W-FRAC-2:N-1]) begin
         sat_relu = {1'b0, {(N-1){1'b1}}};
      end else begin
         sat_relu = s[N-1:0];
      end
   endfunction

   // Operands are sign-extended to 2N so the low 2N product bits are exact.
   assign mul_s      = {{N{inp[N-1]}}, inp} * {{N{weight[N-1]}}, weight};
   assign prod_ext_s = {{(ACC_W-2*N){prod_q[2*N-1]}}, prod_q};
   assign bias_ext_s = {{(ACC_W-N-FRAC){bias[N-1]}}, bias, {FRAC{1'b0}}};

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      prod_d      = prod_q;
      pv_d        = pv_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      beat_s      = 1'b0;
      if (clear) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
         pv_d        = 1'b0;
         cnt_d       = {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  acc_d   = bias_ext_s;
                  cnt_d   = {CNT_W{1'b0}};
                  pv_d    = 1'b0;
                  state_d = ST_ACC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ACC: begin
               beat_s = in_valid & in_ready_q;
               if (pv_q) begin
                  acc_d = acc_q + prod_ext_s;
               end else begin
                  acc_d = acc_q;
               end
               if (beat_s) begin
                  prod_d = mul_s;
                  pv_d   = 1'b1;
                  cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (cnt_q == LAST) begin
                     state_d = ST_DRAIN;
                  end else begin
                     state_d = ST_ACC;
                  end
               end else begin
                  pv_d = 1'b0;
               end
            end
            ST_DRAIN: begin
               if (pv_q) begin
                  acc_d = acc_q + prod_ext_s;
               end else begin
                  acc_d = acc_q;
               end
               pv_d    = 1'b0;
               state_d = ST_SAT;
            end
            ST_SAT: begin
               out_d       = sat_relu(acc_q);
               out_valid_d = 1'b1;
               state_d     = ST_OUT;
            end
            ST_OUT: begin
               if (out_valid_q && out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_OUT;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               pv_d        = 1'b0;
            end
         endcase
      end
      // Handshake flags are registered from the next state so they line up with it.
      in_ready_d = (state_d == ST_ACC);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= {ACC_W{1'b0}};
         prod_q      <= {(2*N){1'b0}};
         pv_q        <= 1'b0;
         cnt_q       <= {CNT_W{1'b0}};
         out_q       <= {N{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         prod_q      <= prod_d;
         pv_q        <= pv_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign busy      = busy_q;

endmodule
